// File: rtl/uart_rx.sv
// UART receiver with 16x oversampling, 2-flop input synchronizer and frame/parity error flags.
// Optional even-parity bit enabled by defining UART_RX_PARITY_EN.
module uart_rx #(
   parameter int unsigned DBIT    = 8,
   parameter int unsigned SB_TICK = 16
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            b_tick,
   input  logic            rx,
   output logic [DBIT-1:0] d_out,
   output logic            rx_done,
   output logic            frame_err,
   output logic            parity_err
);

   localparam int unsigned   NW    = (DBIT > 1) ? $clog2(DBIT) : 1;
   localparam logic [NW-1:0] NLast = NW'(DBIT - 1);
   localparam logic [3:0]    SLast = 4'(SB_TICK - 1);

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StStart  = 3'd1,
      StData   = 3'd2,
`ifdef UART_RX_PARITY_EN
      StParity = 3'd3,
`endif
      StStop   = 3'd4
   } state_t;

   state_t          r_state;
   logic            r_rx_meta;
   logic            r_rx_s;
   logic            r_armed;
   logic [3:0]      r_s;
   logic [NW-1:0]   r_n;
   logic [DBIT-1:0] r_shift;
   logic [DBIT-1:0] r_d_out;
   logic            r_rx_done;
   logic            r_frame_err;

   logic w_s_mid;
   logic w_s_end;

   assign w_s_mid = (r_s == 4'd7);
   assign w_s_end = (r_s == 4'd15);

`ifdef UART_RX_PARITY_EN
   logic r_par_bit;
   logic r_parity_err;
   assign parity_err = r_parity_err;
`else
   assign parity_err = 1'b0;
`endif

   assign d_out     = r_d_out;
   assign rx_done   = r_rx_done;
   assign frame_err = r_frame_err;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_rx_meta    <= 1'b1;
         r_rx_s       <= 1'b1;
         r_state      <= StIdle;
         r_armed      <= 1'b1;
         r_s          <= '0;
         r_n          <= '0;
         r_shift      <= '0;
         r_d_out      <= '0;
         r_rx_done    <= 1'b0;
         r_frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_par_bit    <= 1'b0;
         r_parity_err <= 1'b0;
`endif
      end else begin
         r_rx_meta <= rx;
         r_rx_s    <= r_rx_meta;
         r_rx_done <= 1'b0;
         unique case (r_state)
            StIdle: begin
               // After a framing error, wait for the line to go high before re-arming.
               if (!r_armed) begin
                  if (r_rx_s) r_armed <= 1'b1;
               end else if (!r_rx_s) begin
                  r_state <= StStart;
                  r_s     <= '0;
               end
            end
            StStart: begin
               if (b_tick) begin
                  if (w_s_mid) begin
                     r_s <= '0;
                     r_n <= '0;
                     r_state <= r_rx_s ? StIdle : StData;
                  end else begin
                     r_s <= r_s + 4'd1;
                  end
               end
            end
            StData: begin
               if (b_tick) begin
                  if (w_s_end) begin
                     r_s     <= '0;
                     r_shift <= {r_rx_s, r_shift[DBIT-1:1]};
                     if (r_n == NLast) begin
`ifdef UART_RX_PARITY_EN
                        r_state <= StParity;
`else
                        r_state <= StStop;
`endif
                     end else begin
                        r_n <= r_n + 1'b1;
                     end
                  end else begin
                     r_s <= r_s + 4'd1;
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
               if (b_tick) begin
                  if (w_s_end) begin
                     r_par_bit <= r_rx_s;
                     r_s       <= '0;
                     r_state   <= StStop;
                  end else begin
                     r_s <= r_s + 4'd1;
                  end
               end
            end
`endif
            StStop: begin
               if (b_tick) begin
                  if (r_s == SLast) begin
                     r_s          <= '0;
                     r_state      <= StIdle;
                     r_rx_done    <= 1'b1;
                     r_d_out      <= r_shift;
                     r_frame_err  <= ~r_rx_s;
                     r_armed      <= r_rx_s;
`ifdef UART_RX_PARITY_EN
                     r_parity_err <= ^{r_shift, r_par_bit};
`endif
                  end else begin
                     r_s <= r_s + 4'd1;
                  end
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter DBIT, default 8, number of data bits per frame.
REQ-002 SHALL have parameter SB_TICK, default 16, number of b_tick periods counted for the stop bit.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port b_tick  input  1  16x-oversample tick, one clk wide, from BAUDGEN.
REQ-006 SHALL have port rx  input  1  serial line, idle high, asynchronous to clk.
REQ-007 SHALL have port d_out  output  DBIT  last received data word.
REQ-008 SHALL have port rx_done  output  1  one-clk pulse marking frame completion.
REQ-009 SHALL have port frame_err  output  1  stop-bit error flag, valid with rx_done.
REQ-010 SHALL have port parity_err  output  1  parity error flag, valid with rx_done.

Function
REQ-011 SHALL pass rx through a 2-flop synchronizer; all logic uses the synchronized value (rx_s), adding 2 clk of latency.
REQ-012 SHALL implement states IDLE, START, DATA, PARITY, STOP, with a 4-bit tick counter s and a bit counter n.
REQ-013 IDLE: when armed and rx_s==0, SHALL go to START with s=0; b_tick is not required for this transition.
REQ-014 START: on each b_tick s increments; at the b_tick with s==7, SHALL go to DATA with s=0 and n=0 if rx_s==0, else SHALL return to IDLE (glitch reject, no rx_done).
REQ-015 DATA: at the b_tick with s==15, SHALL shift rx_s into the MSB of the shift register (LSB-first line order) and clear s; after bit n==DBIT-1 SHALL go to PARITY (macro defined) or STOP.
REQ-016 PARITY: at the b_tick with s==15, SHALL capture rx_s as the parity bit and go to STOP with s=0.
REQ-017 STOP: at the b_tick with s==SB_TICK-1, SHALL sample rx_s and return to IDLE.
REQ-018 On the clk following the REQ-017 sample, SHALL pulse rx_done for exactly one clk, load d_out from the shift register, set frame_err=(stop sample==0), and set parity_err per Configuration.
REQ-019 d_out, frame_err and parity_err SHALL hold until the next rx_done.
REQ-020 After a frame with frame_err=1, SHALL stay unarmed in IDLE until rx_s==1 for at least one clk; a held-low line yields exactly one error frame.
REQ-021 Back-to-back frames (next start bit immediately after one stop bit) SHALL be received without loss.
REQ-022 b_tick SHALL be ignored in IDLE; counters only advance on b_tick in the other states.

Reset
REQ-023 On resetn==0, SHALL immediately enter IDLE armed, with s=0, n=0, shift register 0, d_out=0, rx_done=0, frame_err=0, parity_err=0, and synchronizer flops =1.
REQ-024 Reset mid-frame SHALL abort the frame without an rx_done pulse; the first complete frame after release SHALL be received correctly.

Configuration
REQ-025 Macro UART_RX_PARITY_EN defined: the frame SHALL carry one even-parity bit after the data bits; parity_err=1 when the XOR of data and parity bits is 1.
REQ-026 Macro UART_RX_PARITY_EN undefined: the PARITY state SHALL be absent, frames SHALL be 8N1, and parity_err SHALL be tied 0.

Verification
REQ-027 Idle line, then frame 0xA5 at 19200 baud (50 MHz clk, BAUDGEN 16x tick) -> one rx_done pulse, d_out=0xA5, frame_err=0, parity_err=0.
REQ-028 Back-to-back frames 0x00 then 0xFF -> two rx_done pulses, with d_out=0x00 then 0xFF and no errors.
REQ-029 rx low for 3 b_tick periods on an idle line -> no rx_done, FSM in IDLE, next frame 0x3C received correctly.
REQ-030 Frame 0x3C with the stop bit low and the line held low for 3 frame times -> exactly one rx_done with d_out=0x3C and frame_err=1; after rx returns high, frame 0x11 received with frame_err=0.
REQ-031 resetn asserted during data bit 4 -> all outputs 0 immediately, no rx_done; after release, frame 0x5A -> d_out=0x5A.
REQ-032 UART_TX output looped to rx for all 256 values (macro undefined) -> each value matched; with UART_RX_PARITY_EN, 0x01 sent with parity bit 0 -> parity_err=1.
